// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  localparam logic [3:0]  HLT_OPCODE  = 4'hF;
  localparam logic [15:0] INSTR_RESET = 16'h0000;

  function automatic logic is_hlt(input logic [15:0] word);
    return word[15:12] == HLT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_mem_if.sv
// Instruction memory read port between the fetch stage (master) and memory (slave).
interface fetch_mem_if;
  // mem_req is a one-cycle pulse carrying mem_addr; memory answers with exactly one
  // mem_valid/mem_rdata beat L>=1 cycles later. No ready: the master never issues a
  // second request before the response to the first has arrived.
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic [15:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_valid, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_valid, output mem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load on write-enable, clear valid on flush, bubble when decode consumes.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        we_i,
  input  logic        stall_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pcs_i,
  output logic [15:0] instr_o,
  output logic [15:0] pcs_o,
  output logic        valid_o
);

  logic [15:0] instr_q;
  logic [15:0] pcs_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= INSTR_RESET;
      pcs_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (we_i) begin
        instr_q <= instr_i;
        pcs_q   <= pcs_i;
      end
      // An unstalled decode consumes the entry, so without a new write it becomes a bubble.
      if (clr_i)         valid_q <= 1'b0;
      else if (we_i)     valid_q <= 1'b1;
      else if (!stall_i) valid_q <= 1'b0;
    end
  end

  assign instr_o = instr_q;
  assign pcs_o   = pcs_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory reads into IF/ID, PC hold control.
// FETCH_HLT_DETECT_EN: stop fetching once an HLT opcode is written into IF/ID.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        pc_addr,
  input  logic [15:0]        pc_plus2,
  input  logic               flush,
  input  logic               id_stall,
  fetch_mem_if.master        mem,
  output logic               pc_hold,
  output logic [15:0]        instr,
  output logic [15:0]        instr_pcs,
  output logic               instr_valid,
  output logic               halted,
  output fetch_state_e       dbg_state
);

  fetch_state_e state_q;
  logic [15:0]  pend_pcs_q;
  logic [15:0]  hold_buf_q;

  logic         wait_acc;
  logic         hold_acc;
  logic         ifid_we;
  logic         hlt_word;
  logic [15:0]  ifid_instr_d;

  always_comb begin
    wait_acc     = !rst && !flush && (state_q == ST_WAIT) && mem.mem_valid && !id_stall;
    hold_acc     = !rst && !flush && (state_q == ST_HOLD) && !id_stall;
    ifid_we      = wait_acc || hold_acc;
    ifid_instr_d = hold_acc ? hold_buf_q : mem.mem_rdata;
`ifdef FETCH_HLT_DETECT_EN
    hlt_word     = ifid_we && is_hlt(ifid_instr_d);
`else
    hlt_word     = 1'b0;
`endif
    mem.mem_req  = !rst && !flush && (state_q == ST_REQ);
    mem.mem_addr = mem.mem_req ? pc_addr : '0;
    // PC moves on an accepted instruction or on a redirect; a halted fetch never moves it.
    pc_hold = 1'b1;
    if (!rst && (state_q != ST_HALT) && (flush || (ifid_we && !hlt_word))) pc_hold = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pend_pcs_q <= '0;
      hold_buf_q <= '0;
    end else if (flush) begin
      case (state_q)
        ST_WAIT: state_q <= mem.mem_valid ? ST_REQ : ST_DRAIN;
        ST_HOLD: state_q <= ST_REQ;
        default: state_q <= state_q;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          pend_pcs_q <= pc_plus2;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem.mem_valid) begin
            if (id_stall) begin
              hold_buf_q <= mem.mem_rdata;
              state_q    <= ST_HOLD;
            end else begin
              state_q <= hlt_word ? ST_HALT : ST_REQ;
            end
          end
        end
        ST_HOLD: begin
          if (!id_stall) state_q <= hlt_word ? ST_HALT : ST_REQ;
        end
        ST_DRAIN: begin
          if (mem.mem_valid) state_q <= ST_REQ;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .we_i    (ifid_we),
    .stall_i (id_stall),
    .instr_i (ifid_instr_d),
    .pcs_i   (pend_pcs_q),
    .instr_o (instr),
    .pcs_o   (instr_pcs),
    .valid_o (instr_valid)
  );

`ifdef FETCH_HLT_DETECT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC updater + latency memory model, expected-instruction scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  pc_addr;
  logic [15:0]  pc_plus2;
  logic         flush = 1'b0;
  logic         id_stall = 1'b0;
  logic         pc_hold;
  logic [15:0]  instr;
  logic [15:0]  instr_pcs;
  logic         instr_valid;
  logic         halted;
  fetch_state_e dbg_state;

  fetch_mem_if mem_bus ();

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .pc_plus2    (pc_plus2),
    .flush       (flush),
    .id_stall    (id_stall),
    .mem         (mem_bus),
    .pc_hold     (pc_hold),
    .instr       (instr),
    .instr_pcs   (instr_pcs),
    .instr_valid (instr_valid),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  int          checks = 0;
  int          failures = 0;
  int          n_pop = 0;
  logic [31:0] exp_q[$];
  logic [15:0] mem_img[int];

  // PC updater and memory models
  logic [15:0] pc = 16'h0000;
  int          lat = 1;
  bit          mbusy = 1'b0;
  int          mrem = 0;
  logic [15:0] maddr = 16'h0000;
  int          cyc = 0;
  int          req_cyc[$];
  logic [15:0] req_addr[$];

  // Per-cycle samples taken mid-cycle
  logic         s_req, s_hold, s_valid, s_halted;
  logic [15:0]  s_addr, s_instr, s_pcs;
  fetch_state_e s_state;

  assign pc_addr  = pc;
  assign pc_plus2 = pc + 16'd2;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [15:0] w;
    if (mem_img.exists(int'(a))) return mem_img[int'(a)];
    w = (a * 16'h9E37) ^ 16'h5A5A;
    if (w[15:12] == 4'hF) w[15:12] = 4'hE;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs at negedge, then advance the models.
  task automatic tick(input bit fl, input bit st, input logic [15:0] tgt);
    flush    = fl;
    id_stall = st;
    @(negedge clk);
    s_req    = mem_bus.mem_req;
    s_addr   = mem_bus.mem_addr;
    s_hold   = pc_hold;
    s_instr  = instr;
    s_pcs    = instr_pcs;
    s_valid  = instr_valid;
    s_halted = halted;
    s_state  = dbg_state;
    if (rst) begin
      exp_q.delete();
    end else if (s_req) begin
      chk("req_addr_is_pc", s_addr, pc);
      chk("single_outstanding", mbusy, 0);
      exp_q.push_back({word_at(pc), pc + 16'd2});
      req_cyc.push_back(cyc);
      req_addr.push_back(s_addr);
    end
    @(posedge clk);
    #1;
    cyc++;
    mem_bus.mem_valid = 1'b0;
    if (rst) begin
      mbusy = 1'b0;
    end else begin
      if (fl) pc = tgt;
      else if (!s_hold) pc = pc + 16'd2;
      if (s_req) begin
        mbusy = 1'b1;
        mrem  = lat;
        maddr = s_addr;
      end
      if (mbusy) begin
        mrem--;
        if (mrem == 0) begin
          mbusy             = 1'b0;
          mem_bus.mem_valid = 1'b1;
          mem_bus.mem_rdata = word_at(maddr);
        end
      end
    end
  endtask

  task automatic do_reset(input logic [15:0] start);
    rst = 1'b1;
    pc  = start;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_rdata = 16'h0000;
    mbusy = 1'b0;
    mem_img.delete();
    req_cyc.delete();
    req_addr.delete();
    repeat (3) tick(1'b0, 1'b0, 16'h0);
    rst = 1'b0;
    cyc = 1;
  endtask

  // Monitor: a new IF/ID entry appears when valid follows an unstalled cycle.
  bit m_prev_stall = 1'b0;
  bit m_prev_adv   = 1'b0;
  bit m_prev_rst   = 1'b1;
  always @(negedge clk) begin
    bit is_new;
    is_new = (instr_valid === 1'b1) && !m_prev_stall;
    if (!rst && !m_prev_rst) begin
      if (!(is_new && halted === 1'b1)) chk("pc_hold_vs_accept", is_new, m_prev_adv);
      if (is_new) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr: got %0h expected none", instr);
        end else begin
          chk("instr_stream", {instr, instr_pcs}, exp_q.pop_front());
          n_pop++;
        end
      end
    end
    if (!rst && flush) exp_q.delete();
    m_prev_stall = id_stall;
    m_prev_adv   = (pc_hold === 1'b0) && !flush;
    m_prev_rst   = rst;
  end

  initial begin
    bit          fl, st;
    logic [15:0] tgt;
    int          nreq, nadv;

    // Reset values and single L=1 fetch timing
    do_reset(16'h0000);
    mem_img[0] = 16'h1234;
    lat = 1;
    chk("rst_mem_req", s_req, 0);
    chk("rst_mem_addr", s_addr, 0);
    chk("rst_pc_hold", s_hold, 1);
    chk("rst_instr", s_instr, 16'h0000);
    chk("rst_instr_pcs", s_pcs, 0);
    chk("rst_instr_valid", s_valid, 0);
    chk("rst_halted", s_halted, 0);
    chk("rst_state", s_state, ST_REQ);
    tick(1'b0, 1'b0, 16'h0);
    chk("t1_c1_req", s_req, 1);
    chk("t1_c1_addr", s_addr, 16'h0000);
    chk("t1_c1_hold", s_hold, 1);
    tick(1'b0, 1'b0, 16'h0);
    chk("t1_c2_hold", s_hold, 0);
    chk("t1_c2_valid", s_valid, 0);
    tick(1'b0, 1'b0, 16'h0);
    chk("t1_c3_instr", s_instr, 16'h1234);
    chk("t1_c3_pcs", s_pcs, 16'h0002);
    chk("t1_c3_valid", s_valid, 1);

    // L=4: request every five cycles
    do_reset(16'h0000);
    lat = 4;
    repeat (16) tick(1'b0, 1'b0, 16'h0);
    chk("t2_req_count", req_cyc.size() >= 3, 1);
    if (req_cyc.size() >= 3) begin
      chk("t2_gap0", req_cyc[1] - req_cyc[0], 5);
      chk("t2_gap1", req_cyc[2] - req_cyc[1], 5);
      chk("t2_addr0", req_addr[0], 16'h0000);
      chk("t2_addr1", req_addr[1], 16'h0002);
      chk("t2_addr2", req_addr[2], 16'h0004);
    end

    // Decode stall while the response arrives
    do_reset(16'h0000);
    mem_img[0] = 16'h1111;
    mem_img[2] = 16'hA5A5;
    lat = 1;
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'h0);
    chk("t3_c3_instr", s_instr, 16'h1111);
    for (int k = 4; k <= 6; k++) begin
      tick(1'b0, 1'b1, 16'h0);
      chk("t3_stall_instr", s_instr, 16'h1111);
      chk("t3_stall_valid", s_valid, 1);
      chk("t3_stall_hold", s_hold, 1);
      if (k == 5) chk("t3_state_hold", s_state, ST_HOLD);
    end
    tick(1'b0, 1'b0, 16'h0);
    chk("t3_release_hold", s_hold, 0);
    tick(1'b0, 1'b0, 16'h0);
    chk("t3_instr", s_instr, 16'hA5A5);
    chk("t3_pcs", s_pcs, 16'h0004);
    chk("t3_valid", s_valid, 1);

    // Flush two cycles into an L=4 wait
    do_reset(16'h0000);
    mem_img[0] = 16'h2222;
    lat = 1;
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    lat = 4;
    tick(1'b0, 1'b1, 16'h0);
    chk("t4_c3_instr", s_instr, 16'h2222);
    tick(1'b0, 1'b1, 16'h0);
    tick(1'b1, 1'b1, 16'h0040);
    chk("t4_flush_hold", s_hold, 0);
    chk("t4_flush_req", s_req, 0);
    tick(1'b0, 1'b0, 16'h0);
    chk("t4_c6_valid", s_valid, 0);
    chk("t4_c6_state", s_state, ST_DRAIN);
    tick(1'b0, 1'b0, 16'h0);
    chk("t4_c7_req", s_req, 0);
    chk("t4_c7_valid", s_valid, 0);
    tick(1'b0, 1'b0, 16'h0);
    chk("t4_c8_req", s_req, 1);
    chk("t4_c8_addr", s_addr, 16'h0040);
    chk("t4_c8_valid", s_valid, 0);

    // Flush in the same cycle as the response
    do_reset(16'h0000);
    lat = 2;
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0080);
    chk("t5_flush_hold", s_hold, 0);
    chk("t5_flush_req", s_req, 0);
    tick(1'b0, 1'b0, 16'h0);
    chk("t5_req", s_req, 1);
    chk("t5_addr", s_addr, 16'h0080);
    chk("t5_valid", s_valid, 0);
    tick(1'b0, 1'b0, 16'h0);
    chk("t5_valid_next", s_valid, 0);

    // HLT opcode
    do_reset(16'h0000);
    mem_img[0] = 16'hF000;
    lat = 1;
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
`ifdef FETCH_HLT_DETECT_EN
    chk("t6_hlt_accept_hold", s_hold, 1);
    tick(1'b0, 1'b1, 16'h0);
    chk("t6_instr", s_instr, 16'hF000);
    chk("t6_valid", s_valid, 1);
    chk("t6_halted", s_halted, 1);
    nreq = 0;
    nadv = 0;
    repeat (20) begin
      tick(1'b0, 1'b1, 16'h0);
      if (s_req) nreq++;
      if (!s_hold) nadv++;
    end
    chk("t6_no_req", nreq, 0);
    chk("t6_no_advance", nadv, 0);
    chk("t6_valid_kept", s_valid, 1);
    tick(1'b1, 1'b1, 16'h0200);
    chk("t6_flush_hold", s_hold, 1);
    tick(1'b0, 1'b1, 16'h0);
    chk("t6_flush_valid", s_valid, 0);
    chk("t6_still_halted", s_halted, 1);
    chk("t6_state", s_state, ST_HALT);
`else
    chk("t6_hlt_accept_hold", s_hold, 0);
    tick(1'b0, 1'b0, 16'h0);
    chk("t6_instr", s_instr, 16'hF000);
    chk("t6_valid", s_valid, 1);
    chk("t6_halted", s_halted, 0);
    chk("t6_next_req", s_req, 1);
    chk("t6_next_addr", s_addr, 16'h0002);
    nreq = 0;
    repeat (20) begin
      tick(1'b0, 1'b0, 16'h0);
      if (s_req) nreq++;
    end
    chk("t6_fetch_continues", nreq >= 5, 1);
`endif

    // Randomised traffic against the scoreboard
    do_reset(16'h0100);
    n_pop = 0;
    for (int i = 0; i < 2000; i++) begin
      lat = $urandom_range(1, 5);
      fl  = ($urandom_range(0, 24) == 0);
      st  = ($urandom_range(0, 2) == 0);
      tgt = 16'($urandom_range(0, 32767) * 2);
      tick(fl, st, tgt);
    end
    lat = 1;
    repeat (20) tick(1'b0, 1'b0, 16'h0);
    chk("rand_progress", n_pop > 100, 1);
    chk("rand_drained", exp_q.size() <= 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
